// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : UART receiver. Oversamples the asynchronous rx pin, decodes
//               8N1 frames (8E1 when UART_RX_PARITY_EN is defined) and queues
//               received bytes in a small FIFO read through valid/ready.
// Config      : `define UART_RX_PARITY_EN  -> even parity bit after bit 7
// Ports       : clk, rst_n (async, active low)
//               enable         receiver enable, low aborts a frame
//               clock_scale    clocks per bit minus 1 (min effective 3)
//               rx             serial input, idles high
//               data_out       FIFO head byte
//               data_valid     FIFO not empty
//               data_ready     consumer pops head when data_valid is high
//               framing_error  sticky bad stop / bad parity flag
//               overrun_error  sticky byte-dropped-on-full flag
//               clear_errors   pulse clears both sticky flags (set wins)
//               busy           receiver not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int SCALE_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [SCALE_WIDTH-1:0] clock_scale,
  input  logic                   rx,
  output logic [7:0]             data_out,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic                   framing_error,
  output logic                   overrun_error,
  input  logic                   clear_errors,
  output logic                   busy
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [SCALE_WIDTH-1:0] c_MIN_SCALE = SCALE_WIDTH'(3);
  localparam logic [FIFO_DEPTH_LOG2:0] c_FULL_CNT = (FIFO_DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronizer and falling-edge detect
  // --------------------------------------------------------------------------
  logic r_rx_s1, r_rx_s2, r_rx_d;
  logic w_rx, w_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
    end
  end

  assign w_rx   = r_rx_s2;
  assign w_fall = r_rx_d & ~r_rx_s2;

  // Scales below 3 leave too few clocks per bit for a mid-bit sample.
  logic [SCALE_WIDTH-1:0] w_scale;
  assign w_scale = (clock_scale < c_MIN_SCALE) ? c_MIN_SCALE : clock_scale;

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  state_t                 r_state, w_state_nxt;
  logic [SCALE_WIDTH-1:0] r_cnt;
  logic [2:0]             r_bit;
  logic [7:0]             r_shift;
  logic                   w_sample;
  logic                   w_load_start;
  logic                   w_shift_en;
  logic                   w_push;
  logic                   w_ferr_set;
`ifdef UART_RX_PARITY_EN
  logic                   r_par_bad;
  logic                   w_par_bad;
  assign w_par_bad = ^{r_shift, w_rx};
`endif

  assign w_sample = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load_start = 1'b0;
    w_shift_en   = 1'b0;
    w_push       = 1'b0;
    w_ferr_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_nxt  = S_START;
          w_load_start = 1'b1;
        end
      end
      S_START: begin
        if (w_sample) w_state_nxt = w_rx ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_sample) begin
          w_shift_en = 1'b1;
          if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_sample) begin
          w_state_nxt = S_STOP;
          w_ferr_set  = w_par_bad;
        end
      end
`endif
      S_STOP: begin
        if (w_sample) begin
          w_state_nxt = S_IDLE;
          if (w_rx) begin
`ifdef UART_RX_PARITY_EN
            w_push = ~r_par_bad;
`else
            w_push = 1'b1;
`endif
          end else begin
            w_ferr_set = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Disabling drops the partial frame; nothing from it reaches the FIFO.
    if (!enable) begin
      w_state_nxt  = S_IDLE;
      w_load_start = 1'b0;
      w_shift_en   = 1'b0;
      w_push       = 1'b0;
      w_ferr_set   = 1'b0;
    end
  end

  // Bit timing counter, bit index and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      if (w_load_start)
        r_cnt <= w_scale >> 1;
      else if (r_state != S_IDLE)
        r_cnt <= w_sample ? w_scale : r_cnt - SCALE_WIDTH'(1);

      if (r_state == S_START)
        r_bit <= '0;
      else if (w_shift_en)
        r_bit <= r_bit + 3'd1;

      if (w_shift_en)
        r_shift <= {w_rx, r_shift[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_par_bad <= 1'b0;
    else if (w_load_start)
      r_par_bad <= 1'b0;
    else if (r_state == S_PARITY && w_sample)
      r_par_bad <= w_par_bad;
  end
`endif

  // --------------------------------------------------------------------------
  // Receive FIFO
  // --------------------------------------------------------------------------
  logic [7:0]                 r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   r_count;
  logic                       w_pop, w_full, w_do_push, w_overrun;

  assign w_pop     = (r_count != '0) & data_ready;
  assign w_full    = (r_count == c_FULL_CNT);
  // A pop on the same edge frees the slot, so a push into a full FIFO is fine.
  assign w_do_push = w_push & (~w_full | w_pop);
  assign w_overrun = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sticky error flags: a new event wins over a simultaneous clear
  // --------------------------------------------------------------------------
  logic r_ferr, r_oerr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ferr <= 1'b0;
      r_oerr <= 1'b0;
    end else begin
      r_ferr <= w_ferr_set | (r_ferr & ~clear_errors);
      r_oerr <= w_overrun  | (r_oerr & ~clear_errors);
    end
  end

  assign data_out      = r_mem[r_rd_ptr];
  assign data_valid    = (r_count != '0);
  assign framing_error = r_ferr;
  assign overrun_error = r_oerr;
  assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive half of the peripheral UART. The block oversamples the `rx` pin, decodes 8N1 frames (optionally 8E1), and queues received bytes in a small FIFO. The FIFO is read through a valid/ready handshake by the UART register interface. It pairs with the existing UART transmitter in the peripherals subsystem and shares the same `clock_scale` convention.

## Interface
- `FIFO_DEPTH_LOG2`, default 2, FIFO depth = 2^FIFO_DEPTH_LOG2 entries (4).
- `SCALE_WIDTH`, default 16, width of `clock_scale`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  receiver enable; low aborts any frame in progress.
- `clock_scale`  in  SCALE_WIDTH  clocks per bit minus 1; values below 3 are treated as 3.
- `rx`  in  1  serial input, asynchronous; idles high.
- `data_out`  out  8  FIFO head byte.
- `data_valid`  out  1  FIFO not empty.
- `data_ready`  in  1  consumer accepts the head byte when `data_valid` is high.
- `framing_error`  out  1  sticky; set on a bad stop bit (or bad parity).
- `overrun_error`  out  1  sticky; set when a byte is dropped because the FIFO is full.
- `clear_errors`  in  1  one-cycle pulse clears both sticky flags.
- `busy`  out  1  high while not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1) followed by one edge-detect flop.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: a falling edge of synchronized `rx` with `enable`=1 loads the bit counter with `clock_scale>>1` and moves to START.
- Bit counter: counts down; a "sample" occurs when it reaches 0, and it then reloads with the effective `clock_scale`.
- START sample:
  - `rx`=1 is a false start; return to IDLE.
  - `rx`=0 moves to DATA with bit index 0.
- DATA: 8 samples, LSB first, shifted into the shift register. After bit 7 go to PARITY (if compiled in) or STOP.
- STOP sample:
  - `rx`=1: push the byte to the FIFO.
  - `rx`=0: set `framing_error` and discard the byte.
  - Either way, return to IDLE. In IDLE a new frame requires a fresh falling edge, so a break condition does not retrigger.
- FIFO behaviour:
  - Push when full: byte dropped, `overrun_error` set, FIFO contents unchanged.
  - Pop when `data_valid && data_ready`.
  - Push and pop in the same cycle while full: both happen, no overrun.
  - Pointers wrap modulo the depth; count is FIFO_DEPTH_LOG2+1 bits.
- `enable` low forces IDLE next cycle and discards the partial byte. FIFO contents and error flags are kept.
- `clear_errors` in the same cycle as a new error event: the flag ends set (set wins).
- Reset values: `data_out`=0, `data_valid`=0, `framing_error`=0, `overrun_error`=0, `busy`=0. FSM is in IDLE and the FIFO is empty.

## Timing
- Synchronizer plus edge-detect latency: the falling edge is detected 3 `clk` cycles after the `rx` transition.
- Start sample falls `(clock_scale>>1)+1` cycles after detection. Each later sample is `clock_scale+1` cycles apart.
- `data_valid` rises on the cycle after the STOP sample (registered push).
- `data_out` is driven from the FIFO head registers; it holds stable while `data_valid` is high and no pop occurs.
- A pop on edge N exposes the next entry on that same edge; if the FIFO becomes empty, `data_valid` falls.
- `busy` is high from the cycle after edge detection until the cycle after the STOP (or false-start) sample.

## Configuration
- `UART_RX_PARITY_EN` defined: the frame is 8E1.
  - The PARITY state samples one extra bit after bit 7.
  - Parity mismatch (XOR of 8 data bits and parity bit ≠ 0) sets `framing_error` and discards the byte.
  - The STOP check still applies.
- `UART_RX_PARITY_EN` undefined: the frame is 8N1, the PARITY state is absent, and DATA goes directly to STOP.

## Test plan
- Nominal byte: `clock_scale`=15, send 0xA5 as 8N1 → `data_out`=0xA5, `data_valid`=1 one cycle after the stop sample, `framing_error`=0. A pop with `data_ready`=1 → `data_valid`=0.
- False start: 4-cycle low glitch on `rx` with `clock_scale`=15 → return to IDLE, `busy` pulses, no FIFO push.
- Framing error: send 0x3C with stop bit 0 → `framing_error`=1, `data_valid` stays 0. Pulse `clear_errors` → `framing_error`=0.
- Overrun: `data_ready`=0, send 0x01..0x05 → 4 entries held, `overrun_error`=1. Popping yields 0x01, 0x02, 0x03, 0x04, then `data_valid`=0.
- Abort and reset: drop `enable` mid-byte (bit 3), then resend 0x7E → only 0x7E is received. Assert `rst_n`=0 mid-frame → all outputs return to reset values immediately.
- With `UART_RX_PARITY_EN`: send 0x0F with parity 0 → received as 0x0F. Send 0x0F with parity 1 → `framing_error`=1 and no push.
